collision_tracker: RTL and testbench

COLLISION_TRACKER -- requirements
Module: collision_tracker

---
 rtl/collision_tracker_if.sv | 11 +
 rtl/collision_tracker.sv | 209 ++++++++++++++++++++
 tb/tb_collision_tracker.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_tracker_if.sv
// Tile-map write bus for collision_tracker: one write strobe, address and data bit.
interface collision_tracker_if #(
  parameter int AW = 12
) ();
  logic          map_we;
  logic [AW-1:0] map_waddr;
  logic          map_wdata;

  modport master (output map_we, map_waddr, map_wdata);
  modport slave  (input  map_we, map_waddr, map_wdata);
endinterface

// File: rtl/collision_tracker.sv
// Pixel-rate tile/coin collision tracker with per-frame coin commit scan.
// Optional macro COIN_SCORE_EN builds the saturating score counter; otherwise score_out is tied to 0.
module collision_tracker #(
  parameter int MAP_W     = 211,
  parameter int MAP_H     = 15,
  parameter int TILE_LOG2 = 4,
  parameter int N_COINS   = 6,
  parameter int SCORE_W   = 8
) (
  input  logic                               pixel_clk_in,
  input  logic                               rst_n_in,
  input  logic [10:0]                        hcount_in,
  input  logic [9:0]                         vcount_in,
  input  logic [11:0]                        offset_in,
  input  logic                               new_frame_in,
  input  logic                               level_clear_in,
  input  logic                               collision_info_in,
  input  logic [N_COINS*13-1:0]              coin_x_in,
  input  logic [N_COINS*13-1:0]              coin_y_in,
  input  logic                               map_we_in,
  input  logic [$clog2(MAP_W*MAP_H)-1:0]     map_waddr_in,
  input  logic                               map_wdata_in,
  output logic                               collision_out,
  output logic [N_COINS-1:0]                 coin_hit_out,
  output logic [N_COINS-1:0]                 coin_collected_out,
  output logic                               collect_pulse_out,
  output logic [SCORE_W-1:0]                 score_out,
  output logic                               busy_out
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = $clog2(MAP_W * MAP_H);
  localparam int IW    = (N_COINS > 1) ? $clog2(N_COINS) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_COINS - 1);
  localparam logic [13:0]   COIN_SPAN = 14'((1 << TILE_LOG2) - 1);

  typedef enum logic {ST_ACTIVE, ST_COMMIT} state_t;

  logic mem [DEPTH];

  logic [11:0] world_x;
  logic [31:0] tile_col, tile_row, tile_lin;
  logic        tile_in_range;

  logic [AW-1:0] addr_p1_d, addr_p1_q;
  logic          inr_p1_d, inr_p1_q;
  logic          info_p1_d, info_p1_q;
  logic [11:0]   wx_p1_d, wx_p1_q;
  logic [9:0]    wy_p1_d, wy_p1_q;

  logic          map_p2_d, map_p2_q;
  logic          info_p2_d, info_p2_q;
  logic [11:0]   wx_p2_d, wx_p2_q;
  logic [9:0]    wy_p2_d, wy_p2_q;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [N_COINS-1:0]  coin_hit_q;
  logic [N_COINS-1:0]  coin_collected_q;
  logic                collect_pulse_q;
  logic                busy_q;

  logic [N_COINS-1:0]  coin_match;
  logic [13:0]         cx, cy, wx14, wy14;
  logic                collect_now;

  // Stage p0: world coordinates and tile address; columns past MAP_W must not alias into the next row.
  always_comb begin
    world_x       = {1'b0, hcount_in} + offset_in;
    tile_col      = 32'(world_x >> TILE_LOG2);
    tile_row      = 32'(vcount_in >> TILE_LOG2);
    tile_in_range = (tile_col < 32'(MAP_W)) && (tile_row < 32'(MAP_H));
    tile_lin      = tile_col + tile_row * 32'(MAP_W);
    addr_p1_d     = tile_in_range ? AW'(tile_lin) : '0;
    inr_p1_d      = tile_in_range;
    info_p1_d     = collision_info_in;
    wx_p1_d       = world_x;
    wy_p1_d       = vcount_in;
  end

  // Stage p1 -> p2: registered RAM read; a write landing on this edge is seen by later reads only.
  always_comb begin
    map_p2_d  = inr_p1_q ? mem[addr_p1_q] : 1'b0;
    info_p2_d = info_p1_q;
    wx_p2_d   = wx_p1_q;
    wy_p2_d   = wy_p1_q;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (map_we_in && (32'(map_waddr_in) < 32'(DEPTH))) begin
      mem[map_waddr_in] <= map_wdata_in;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_p1_q <= '0;
      inr_p1_q  <= 1'b0;
      info_p1_q <= 1'b0;
      wx_p1_q   <= '0;
      wy_p1_q   <= '0;
      map_p2_q  <= 1'b0;
      info_p2_q <= 1'b0;
      wx_p2_q   <= '0;
      wy_p2_q   <= '0;
    end else begin
      addr_p1_q <= addr_p1_d;
      inr_p1_q  <= inr_p1_d;
      info_p1_q <= info_p1_d;
      wx_p1_q   <= wx_p1_d;
      wy_p1_q   <= wy_p1_d;
      map_p2_q  <= map_p2_d;
      info_p2_q <= info_p2_d;
      wx_p2_q   <= wx_p2_d;
      wy_p2_q   <= wy_p2_d;
    end
  end

  // Stage p2: coin box test in 14 bits so a coin near x=4095 never matches wrapped pixels.
  always_comb begin
    coin_match = '0;
    cx         = '0;
    cy         = '0;
    wx14       = {2'b00, wx_p2_q};
    wy14       = {4'b0000, wy_p2_q};
    for (int i = 0; i < N_COINS; i++) begin
      cx = {1'b0, coin_x_in[13*i +: 13]};
      cy = {1'b0, coin_y_in[13*i +: 13]};
      coin_match[i] = info_p2_q &&
                      (wx14 >= cx) && (wx14 <= cx + COIN_SPAN) &&
                      (wy14 >= cy) && (wy14 <= cy + COIN_SPAN);
    end
  end

  assign collect_now = (state_q == ST_COMMIT) && coin_hit_q[idx_q] && !coin_collected_q[idx_q];

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= ST_ACTIVE;
      idx_q            <= '0;
      coin_hit_q       <= '0;
      coin_collected_q <= '0;
      collect_pulse_q  <= 1'b0;
      busy_q           <= 1'b0;
    end else if (level_clear_in) begin
      state_q          <= ST_ACTIVE;
      idx_q            <= '0;
      coin_hit_q       <= '0;
      coin_collected_q <= '0;
      collect_pulse_q  <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      collect_pulse_q <= collect_now;
      case (state_q)
        ST_ACTIVE: begin
          coin_hit_q <= coin_hit_q | coin_match;
          if (new_frame_in) begin
            state_q <= ST_COMMIT;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (collect_now) begin
            coin_collected_q[idx_q] <= 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_q    <= ST_ACTIVE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            coin_hit_q <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_ACTIVE;
      endcase
    end
  end

`ifdef COIN_SCORE_EN
  logic [SCORE_W-1:0] score_q;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      score_q <= '0;
    end else if (level_clear_in) begin
      score_q <= '0;
    end else if (collect_now) begin
      score_q <= sat_inc(score_q);
    end
  end

  assign score_out = score_q;
`else
  assign score_out = '0;
`endif

  assign collision_out      = map_p2_q | info_p2_q;
  assign coin_hit_out       = coin_hit_q;
  assign coin_collected_out = coin_collected_q;
  assign collect_pulse_out  = collect_pulse_q;
  assign busy_out           = busy_q;

endmodule

// File: tb/tb_collision_tracker.sv
// Randomized self-checking bench for collision_tracker against a tile/coin reference model.
module tb_collision_tracker;

  localparam int MAP_W = 211;
  localparam int MAP_H = 15;
  localparam int TL    = 4;
  localparam int NC    = 6;
  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = $clog2(DEPTH);
`ifdef COIN_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [11:0]      offset;
  logic             new_frame, level_clear, info;
  logic [NC*13-1:0] coin_x, coin_y;

  logic          col_a, pulse_a, busy_a;
  logic [NC-1:0] hit_a, coll_a;
  logic [7:0]    score_a;
  logic          col_b, pulse_b, busy_b;
  logic [NC-1:0] hit_b, coll_b;
  logic [1:0]    score_b;

  collision_tracker_if #(.AW(AW)) mif ();

  collision_tracker #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_LOG2(TL), .N_COINS(NC), .SCORE_W(8)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .offset_in(offset), .new_frame_in(new_frame), .level_clear_in(level_clear),
    .collision_info_in(info), .coin_x_in(coin_x), .coin_y_in(coin_y),
    .map_we_in(mif.map_we), .map_waddr_in(mif.map_waddr), .map_wdata_in(mif.map_wdata),
    .collision_out(col_a), .coin_hit_out(hit_a), .coin_collected_out(coll_a),
    .collect_pulse_out(pulse_a), .score_out(score_a), .busy_out(busy_a));

  collision_tracker #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TILE_LOG2(TL), .N_COINS(NC), .SCORE_W(2)) dut_sat (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .offset_in(offset), .new_frame_in(new_frame), .level_clear_in(level_clear),
    .collision_info_in(info), .coin_x_in(coin_x), .coin_y_in(coin_y),
    .map_we_in(mif.map_we), .map_waddr_in(mif.map_waddr), .map_wdata_in(mif.map_wdata),
    .collision_out(col_b), .coin_hit_out(hit_b), .coin_collected_out(coll_b),
    .collect_pulse_out(pulse_b), .score_out(score_b), .busy_out(busy_b));

  bit            map_m [DEPTH];
  logic [NC-1:0] hit_m, coll_m;
  int            score_m, score2_m;
  int            checks = 0;
  int            errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_map(int wx, int wy);
    int c, r;
    c = wx >> TL;
    r = wy >> TL;
    if (c < MAP_W && r < MAP_H) return map_m[r*MAP_W + c];
    return 1'b0;
  endfunction

  function automatic logic [NC-1:0] coin_box(int wx, int wy);
    logic [NC-1:0] m;
    int cx, cy;
    m = '0;
    for (int i = 0; i < NC; i++) begin
      cx = int'(coin_x[13*i +: 13]);
      cy = int'(coin_y[13*i +: 13]);
      if (wx >= cx && wx <= cx + 15 && wy >= cy && wy <= cy + 15) m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic set_coin(input int i, input int x, input int y);
    coin_x[13*i +: 13] = 13'(x);
    coin_y[13*i +: 13] = 13'(y);
  endtask

  task automatic park_coins();
    for (int i = 0; i < NC; i++) set_coin(i, 8000, 8000);
  endtask

  task automatic drive_px(input int h, input int v, input int off, input bit inf);
    hcount = 11'(h);
    vcount = 10'(v);
    offset = 12'(off);
    info   = inf;
    if (inf) hit_m = hit_m | coin_box((h + off) % 4096, v);
    step();
  endtask

  task automatic flush();
    info = 1'b0;
    repeat (3) step();
  endtask

  task automatic write_map(input int a, input bit val);
    mif.map_we    = 1'b1;
    mif.map_waddr = AW'(a);
    mif.map_wdata = val;
    step();
    mif.map_we    = 1'b0;
    map_m[a]      = val;
  endtask

  task automatic do_level_clear();
    level_clear = 1'b1;
    step();
    level_clear = 1'b0;
    hit_m = '0; coll_m = '0; score_m = 0; score2_m = 0;
  endtask

  task automatic apply_frame(output int n);
    logic [NC-1:0] newly;
    newly    = hit_m & ~coll_m;
    n        = $countones(newly);
    coll_m   = coll_m | newly;
    score_m  = (score_m + n > 255) ? 255 : score_m + n;
    score2_m = (score2_m + n > 3) ? 3 : score2_m + n;
    hit_m    = '0;
  endtask

  task automatic run_frame(output int busy_cnt, output int pa, output int pb, output int first_idx);
    busy_cnt = 0; pa = 0; pb = 0; first_idx = -1;
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (busy_a) busy_cnt++;
      if (pulse_a) begin
        pa++;
        if (first_idx < 0) first_idx = j - 1;
      end
      if (pulse_b) pb++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({col_a, hit_a, coll_a, pulse_a, score_a, busy_a} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", {col_a, hit_a, coll_a, pulse_a, score_a, busy_a});
    end
    checks++;
    if ({col_b, hit_b, coll_b, pulse_b, score_b, busy_b} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs_sat: got %h exp 0", {col_b, hit_b, coll_b, pulse_b, score_b, busy_b});
    end
    step();
    rst_n = 1'b1;
    mif.map_we = 1'b1;
    mif.map_wdata = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      mif.map_waddr = AW'(a);
      map_m[a] = 1'b0;
      step();
    end
    mif.map_we = 1'b0;
  endtask

  task automatic test_map();
    int h[9]   = '{40, 47, 48, 31, 40, 2000, 0,   40,  3408};
    int v[9]   = '{20, 31, 20, 20, 15, 20,   0,   260, 0};
    int off[9] = '{0,  0,  0,  0,  0,  2136, 0,   0,   0};
    bit inf[9] = '{0,  0,  0,  0,  0,  0,    1,   0,   0};
    bit expv;
    write_map(2 + 1*MAP_W, 1'b1);
    for (int k = 0; k < 9; k++) begin
      expv = exp_map((h[k] + off[k]) % 4096, v[k]) | inf[k];
      drive_px(h[k], v[k], off[k], inf[k]);
      info = 1'b0;
      step();
      checks++;
      if (col_a !== expv) begin
        errors++;
        $display("FAIL map_pixel_%0d: got %b exp %b", k, col_a, expv);
      end
    end
  endtask

  task automatic test_random_map();
    int written[$];
    bit q[$];
    int a, h, v, off, wx, wy;
    bit inf, expv;
    for (int k = 0; k < 30; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      if (a == 2 + MAP_W) a = a + 1;
      write_map(a, 1'b1);
      written.push_back(a);
    end
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        a   = written[$urandom_range(0, written.size() - 1)];
        wx  = (a % MAP_W) * 16 + $urandom_range(0, 15);
        wy  = (a / MAP_W) * 16 + $urandom_range(0, 15);
        off = (wx > 2047) ? wx - $urandom_range(0, 2047) : $urandom_range(0, wx);
        h   = wx - off;
        v   = wy;
      end else begin
        h   = $urandom_range(0, 2047);
        v   = $urandom_range(0, 300);
        off = $urandom_range(0, 4095);
      end
      inf  = ($urandom_range(0, 7) == 0);
      expv = exp_map((h + off) % 4096, v) | inf;
      q.push_back(expv);
      drive_px(h, v, off, inf);
      if (q.size() >= 2) begin
        expv = q.pop_front();
        checks++;
        if (col_a !== expv) begin
          errors++;
          $display("FAIL random_map_%0d: got %b exp %b", k, col_a, expv);
        end
      end
    end
    info = 1'b0;
    step();
    expv = q.pop_front();
    checks++;
    if (col_a !== expv) begin
      errors++;
      $display("FAIL random_map_tail: got %b exp %b", col_a, expv);
    end
  endtask

  task automatic test_coin_edges();
    int h[6]   = '{216, 200, 199, 2000, 215, 2047};
    int off[6] = '{0,   0,   0,   2101, 0,   2048};
    int v[6]   = '{60,  76,  60,  0,    75,  0};
    do_level_clear();
    park_coins();
    set_coin(2, 200, 60);
    set_coin(1, 4090, 0);
    for (int k = 0; k < 6; k++) begin
      drive_px(h[k], v[k], off[k], 1'b1);
      flush();
      checks++;
      if (hit_a !== hit_m) begin
        errors++;
        $display("FAIL coin_edge_%0d: got %h exp %h", k, hit_a, hit_m);
      end
    end
    do_level_clear();
  endtask

  task automatic test_coin_collect();
    int bc, pa, pb, fi, n;
    park_coins();
    set_coin(3, 100, 50);
    drive_px(85, 55, 20, 1'b1);
    flush();
    checks++;
    if (hit_a !== hit_m || hit_m !== 6'h08) begin
      errors++;
      $display("FAIL coin3_hit: got %h exp %h", hit_a, hit_m);
    end
    run_frame(bc, pa, pb, fi);
    apply_frame(n);
    checks++;
    if (bc !== NC) begin errors++; $display("FAIL busy_cycles: got %0d exp %0d", bc, NC); end
    checks++;
    if (pa !== n) begin errors++; $display("FAIL collect_pulses: got %0d exp %0d", pa, n); end
    checks++;
    if (fi !== 3) begin errors++; $display("FAIL pulse_index: got %0d exp 3", fi); end
    checks++;
    if (coll_a !== coll_m) begin errors++; $display("FAIL collected: got %h exp %h", coll_a, coll_m); end
    checks++;
    if (score_a !== 8'(SCORE_EN ? score_m : 0)) begin
      errors++; $display("FAIL score_first: got %0d exp %0d", score_a, SCORE_EN ? score_m : 0);
    end
    checks++;
    if (hit_a !== 6'h00) begin errors++; $display("FAIL hit_cleared: got %h exp 0", hit_a); end
  endtask

  task automatic test_recollect();
    int bc, pa, pb, fi, n;
    drive_px(85, 55, 20, 1'b1);
    flush();
    checks++;
    if (hit_a !== hit_m) begin errors++; $display("FAIL rehit: got %h exp %h", hit_a, hit_m); end
    run_frame(bc, pa, pb, fi);
    apply_frame(n);
    checks++;
    if (pa !== n) begin errors++; $display("FAIL recollect_pulses: got %0d exp %0d", pa, n); end
    checks++;
    if (score_a !== 8'(SCORE_EN ? score_m : 0)) begin
      errors++; $display("FAIL recollect_score: got %0d exp %0d", score_a, SCORE_EN ? score_m : 0);
    end
  endtask

  task automatic test_ignore_in_commit();
    int bc;
    bc = 0;
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (busy_a) bc++;
      hcount    = 11'd85; vcount = 10'd55; offset = 12'd20;
      info      = (j == 1);
      new_frame = (j == 2);
      step();
    end
    info = 1'b0; new_frame = 1'b0;
    checks++;
    if (bc !== NC) begin errors++; $display("FAIL commit_ignores_frame: got %0d exp %0d", bc, NC); end
    checks++;
    if (hit_a !== 6'h00) begin errors++; $display("FAIL commit_ignores_hit: got %h exp 0", hit_a); end
  endtask

  task automatic test_random_coins();
    int bc, pa, pb, fi, n;
    do_level_clear();
    for (int i = 0; i < NC; i++) set_coin(i, $urandom_range(0, 150), $urandom_range(0, 100));
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 150; k++)
        drive_px($urandom_range(0, 170), $urandom_range(0, 120), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      flush();
      checks++;
      if (hit_a !== hit_m) begin errors++; $display("FAIL rnd_hit_%0d: got %h exp %h", r, hit_a, hit_m); end
      run_frame(bc, pa, pb, fi);
      apply_frame(n);
      checks++;
      if (pa !== n || pb !== n) begin
        errors++; $display("FAIL rnd_pulses_%0d: got %0d/%0d exp %0d", r, pa, pb, n);
      end
      checks++;
      if (coll_a !== coll_m) begin errors++; $display("FAIL rnd_coll_%0d: got %h exp %h", r, coll_a, coll_m); end
      checks++;
      if (score_a !== 8'(SCORE_EN ? score_m : 0) || score_b !== 2'(SCORE_EN ? score2_m : 0)) begin
        errors++;
        $display("FAIL rnd_score_%0d: got %0d/%0d exp %0d/%0d", r, score_a, score_b,
                 SCORE_EN ? score_m : 0, SCORE_EN ? score2_m : 0);
      end
    end
  endtask

  task automatic test_saturation();
    int bc, pa, pb, fi, n;
    do_level_clear();
    park_coins();
    for (int i = 0; i < 4; i++) set_coin(i, 50*i + 10, 200);
    for (int i = 0; i < 4; i++) drive_px(50*i + 12, 205, 0, 1'b1);
    flush();
    run_frame(bc, pa, pb, fi);
    apply_frame(n);
    checks++;
    if (pb !== 4) begin errors++; $display("FAIL sat_pulses: got %0d exp 4", pb); end
    checks++;
    if (score_b !== 2'(SCORE_EN ? 3 : 0)) begin
      errors++; $display("FAIL sat_score: got %0d exp %0d", score_b, SCORE_EN ? 3 : 0);
    end
    checks++;
    if (score_a !== 8'(SCORE_EN ? 4 : 0)) begin
      errors++; $display("FAIL wide_score: got %0d exp %0d", score_a, SCORE_EN ? 4 : 0);
    end
  endtask

  task automatic test_level_clear();
    bit expv;
    do_level_clear();
    for (int i = 0; i < 3; i++) drive_px(50*i + 12, 205, 0, 1'b1);
    flush();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    step();
    step();
    checks++;
    if (coll_a !== 6'h03 || busy_a !== 1'b1) begin
      errors++; $display("FAIL pre_clear: got coll %h busy %b exp 03/1", coll_a, busy_a);
    end
    level_clear = 1'b1;
    step();
    level_clear = 1'b0;
    hit_m = '0; coll_m = '0; score_m = 0; score2_m = 0;
    checks++;
    if ({col_a, hit_a, coll_a, pulse_a, score_a, busy_a} !== 23'd0) begin
      errors++; $display("FAIL level_clear_outputs: got %h exp 0", {col_a, hit_a, coll_a, pulse_a, score_a, busy_a});
    end
    step();
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL level_clear_active: got %b exp 0", busy_a); end
    level_clear = 1'b1;
    new_frame   = 1'b1;
    step();
    level_clear = 1'b0;
    new_frame   = 1'b0;
    step();
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL clear_over_frame: got %b exp 0", busy_a); end
    expv = exp_map(40, 20);
    drive_px(40, 20, 0, 1'b0);
    step();
    checks++;
    if (col_a !== expv || expv !== 1'b1) begin
      errors++; $display("FAIL map_after_clear: got %b exp %b", col_a, expv);
    end
  endtask

  task automatic test_async_reset();
    bit expv;
    do_level_clear();
    drive_px(12, 205, 0, 1'b1);
    flush();
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    step();
    step();
    checks++;
    if (coll_a !== 6'h01 || busy_a !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got coll %h busy %b exp 01/1", coll_a, busy_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({col_a, hit_a, coll_a, pulse_a, score_a, busy_a} !== 23'd0) begin
      errors++; $display("FAIL async_reset: got %h exp 0", {col_a, hit_a, coll_a, pulse_a, score_a, busy_a});
    end
    step();
    rst_n = 1'b1;
    hit_m = '0; coll_m = '0; score_m = 0; score2_m = 0;
    expv = exp_map(40, 20);
    drive_px(40, 20, 0, 1'b0);
    step();
    checks++;
    if (col_a !== expv || busy_a !== 1'b0) begin
      errors++; $display("FAIL map_after_reset: got %b busy %b exp %b/0", col_a, busy_a, expv);
    end
  endtask

  initial begin
    hcount = '0; vcount = '0; offset = '0;
    new_frame = 1'b0; level_clear = 1'b0; info = 1'b0;
    mif.map_we = 1'b0; mif.map_waddr = '0; mif.map_wdata = 1'b0;
    hit_m = '0; coll_m = '0; score_m = 0; score2_m = 0;
    park_coins();
    test_reset();
    test_map();
    test_random_map();
    test_coin_edges();
    test_coin_collect();
    test_recollect();
    test_ignore_in_commit();
    test_random_coins();
    test_saturation();
    test_level_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
